// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8N1 UART transmitter serving a level tx_ready handshake.
// Ports: clk, rst (sync, active-high), tx_ready, tx_data in;
//        tx_line (idles high), tx_done (1-cycle pulse), tx_busy out.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_line,
    output logic                  tx_done,
    output logic                  tx_busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE,
        S_RELEASE
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  line_q, line_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  bit_end;
    logic [DATA_WIDTH-1:0] shifted;

    assign bit_end = (cnt_q == CNT_LAST);
    assign shifted = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        line_d  = line_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        // Baud counter only runs while a bit is on the line.
        if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                if (tx_ready) begin
                    shift_d = tx_data;
                    busy_d  = 1'b1;
                    line_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    line_d  = shift_q[0];
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // Next bit to drive is bit 0 of the shifted value.
                    shift_d = shifted;
                    if (idx_q != IDX_LAST) begin
                        idx_d  = idx_q + IDX_W'(1);
                        line_d = shifted[0];
                    end else begin
                        line_d  = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                line_d  = 1'b1;
                // A still-held request must drop before another frame.
                state_d = tx_ready ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                line_d = 1'b1;
                if (!tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                line_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_line = line_q;
    assign tx_done = done_q;
    assign tx_busy = busy_q;

endmodule
